// File: rtl/cpu_clk_ctrl.sv
// Single-clock CPU clock-enable controller: full/divided-rate run, debounced single-step,
// halt/resume and N PC breakpoints. Everything stays on clk_in; the CPU advances only on cpu_ce.
module cpu_clk_ctrl #(
  parameter int DIV_W        = 32,
  parameter int N_BP         = 4,
  parameter int CNT_W        = 32,
  parameter int DEB_CYCLES   = 1000,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 div_en,
  input  logic [DIV_W-1:0]     div_val,
  input  logic [31:0]          pc,
  input  logic                 fetch,
  input  logic [32*N_BP-1:0]   bp_addr,
  input  logic [N_BP-1:0]      bp_en,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 step_btn,
  output logic                 cpu_ce,
  output logic                 halted,
  output logic [N_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 slow_clk
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;
  localparam state_t RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               slow_clk_q, slow_clk_d;
  logic [N_BP-1:0]    bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d;
  logic               deb_q, deb_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               step_pulse_q, step_pulse_d;
  logic               skip_q, skip_d;

  logic               tick, fire, bp_match, ce;
  logic [N_BP-1:0]    match_vec;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tick       = (div_cnt_q == div_val);
    div_cnt_d  = (tick || div_cnt_q > div_val) ? '0 : div_cnt_q + DIV_W'(1);
    slow_clk_d = tick ? ~slow_clk_q : slow_clk_q;
    for (int i = 0; i < N_BP; i++) begin
      match_vec[i] = bp_en[i] && (pc == bp_addr[32*i +: 32]);
    end
    bp_match = fetch && (|match_vec) && !skip_q;
  end

  // Button: two-flop synchroniser, then a level that only moves after DEB_CYCLES
  // consecutive samples disagree with it; a rising debounced level yields one pulse.
  always_comb begin
    sync1_d   = step_btn;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) deb_d = sync2_q;
      else                       deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
    step_pulse_d = deb_d && !deb_q;
  end

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    skip_d   = skip_q;
    ce       = 1'b0;
    fire     = div_en ? tick : 1'b1;
    unique case (state_q)
      ST_RUN: begin
        // A matching instruction is held back so the CPU stops with pc at the breakpoint.
        ce = fire && !bp_match && !halt_req;
        if (halt_req) state_d = ST_HALT;
        if (fire && bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = match_vec;
        end
      end
      ST_HALT: begin
        if (resume) begin
          if (!halt_req) begin
            state_d  = ST_RUN;
            skip_d   = 1'b1;
            bp_hit_d = '0;
          end
        end else if (step_pulse_q) begin
          state_d  = ST_STEP;
          bp_hit_d = '0;
        end
      end
      ST_STEP: begin
        ce      = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
    if (ce) skip_d = 1'b0;
    cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, ce};
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      div_cnt_q     <= '0;
      slow_clk_q    <= 1'b0;
      bp_hit_q      <= '0;
      cycle_count_q <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_q         <= 1'b0;
      deb_cnt_q     <= '0;
      step_pulse_q  <= 1'b0;
      skip_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      slow_clk_q    <= slow_clk_d;
      bp_hit_q      <= bp_hit_d;
      cycle_count_q <= cycle_count_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      deb_cnt_q     <= deb_cnt_d;
      step_pulse_q  <= step_pulse_d;
      skip_q        <= skip_d;
    end
  end

  assign cpu_ce      = ce && !reset;
  assign halted      = (state_q != ST_RUN);
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_count_q;
  assign slow_clk    = slow_clk_q;

endmodule
